// File: rtl/img_proc_pkg.sv
// Shared types for the image-processing tracking path.
// Coordinate width, tracker states and the row/col bundle.
package img_proc_pkg;

   localparam int COORD_W = 11;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      LOST
   } track_state_t;

   typedef struct packed {
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
   } coord_t;

endpackage

// File: rtl/coord_avg_buf.sv
// One-axis boxcar history: circular buffer plus running sum.
// Seed fills every entry; push replaces the oldest entry.
module coord_avg_buf #(
   parameter int COORD_W = 11,
   parameter int DEPTH   = 4
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               seed,
   input  logic               push,
   input  logic [COORD_W-1:0] din,
   output logic [COORD_W-1:0] avg
);
   import img_proc_pkg::*;

   localparam int LOG2  = $clog2(DEPTH);
   localparam int SUM_W = COORD_W + LOG2;

   logic [COORD_W-1:0] hist [DEPTH];
   logic [LOG2-1:0]    wr_ptr;
   logic [SUM_W-1:0]   sum;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         for (int i = 0; i < DEPTH; i++)
            hist[i] <= '0;
         wr_ptr <= '0;
         sum    <= '0;
      end else if (seed) begin
         for (int i = 0; i < DEPTH; i++)
            hist[i] <= din;
         wr_ptr <= '0;
         sum    <= SUM_W'(din) << LOG2;
      end else if (push) begin
         hist[wr_ptr] <= din;
         wr_ptr       <= wr_ptr + LOG2'(1);
         sum          <= sum + SUM_W'(din)
                             - SUM_W'(hist[wr_ptr]);
      end
   end

   assign avg = sum[SUM_W-1:LOG2];

endmodule

// File: rtl/coord_smoother.sv
// Centroid smoother: boxcar average, outlier rejection,
// lost-target detection and a valid/ready result port.
module coord_smoother #(
   parameter int COORD_W     = img_proc_pkg::COORD_W,
   parameter int DEPTH       = 4,
   parameter int JUMP_THRESH = 64,
   parameter int MAX_REJECTS = 3,
   parameter int LOST_FRAMES = 8
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [COORD_W-1:0] iRow,
   input  logic [COORD_W-1:0] iCol,
   input  logic               iVALID_COORD,
   input  logic               iFRAME_TICK,
   input  logic               iREADY,
   output logic [COORD_W-1:0] oRow,
   output logic [COORD_W-1:0] oCol,
   output logic               oVALID,
   output logic               oTRACKING,
   output logic [7:0]         oREJECTS
);
   import img_proc_pkg::*;

   localparam int LW = $clog2(LOST_FRAMES + 1);
   localparam logic [LW-1:0] LOST_MAX =
      LW'(LOST_FRAMES);
   localparam logic [7:0] REJ_MAX = 8'(MAX_REJECTS);
   localparam logic [COORD_W-1:0] JT =
      COORD_W'(JUMP_THRESH);

   track_state_t state_q, state_d;

   logic               vld_q;
   logic               upd_q;
   logic [LW-1:0]      lost_q, lost_d;
   logic [7:0]         rej_run_q, rej_run_d;
   logic [7:0]         rej_tot_q, rej_tot_d;
   logic               strobe;
   logic               in_gate;
   logic               seed;
   logic               push;
   logic               enter_lost;
   logic [COORD_W-1:0] avg_row, avg_col;
   logic [COORD_W-1:0] d_row, d_col;

   function automatic logic [COORD_W-1:0] absdiff(
      input logic [COORD_W-1:0] a,
      input logic [COORD_W-1:0] b
   );
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   coord_avg_buf #(
      .COORD_W (COORD_W),
      .DEPTH   (DEPTH)
   ) u_row (
      .iCLK (iCLK),
      .iRST (iRST),
      .seed (seed),
      .push (push),
      .din  (iRow),
      .avg  (avg_row)
   );

   coord_avg_buf #(
      .COORD_W (COORD_W),
      .DEPTH   (DEPTH)
   ) u_col (
      .iCLK (iCLK),
      .iRST (iRST),
      .seed (seed),
      .push (push),
      .din  (iCol),
      .avg  (avg_col)
   );

   assign strobe  = iVALID_COORD & ~vld_q;
   assign d_row   = absdiff(iRow, avg_row);
   assign d_col   = absdiff(iCol, avg_col);
   assign in_gate = (d_row <= JT) && (d_col <= JT);

   always_comb begin
      state_d   = state_q;
      lost_d    = lost_q;
      rej_run_d = rej_run_q;
      rej_tot_d = rej_tot_q;
      seed      = 1'b0;
      push      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (strobe) begin
               seed    = 1'b1;
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (strobe) begin
               if (in_gate)
                  push = 1'b1;
               else if (rej_run_q + 8'd1 >= REJ_MAX)
                  seed = 1'b1;
               else begin
                  rej_run_d = rej_run_q + 8'd1;
                  if (rej_tot_q != 8'hFF)
                     rej_tot_d = rej_tot_q + 8'd1;
               end
            end
            // An accepted sample beats a coincident tick
            if (seed || push)
               lost_d = '0;
            else if (iFRAME_TICK && lost_q != LOST_MAX)
               lost_d = lost_q + LW'(1);
            if (lost_d == LOST_MAX)
               state_d = LOST;
         end
         LOST: begin
            if (strobe) begin
               seed    = 1'b1;
               state_d = TRACK;
            end
         end
         default: state_d = IDLE;
      endcase
      if (seed || push) begin
         rej_run_d = '0;
         lost_d    = '0;
      end
   end

   assign enter_lost = (state_q == TRACK) &&
                       (state_d == LOST);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q   <= IDLE;
         lost_q    <= '0;
         rej_run_q <= '0;
         rej_tot_q <= '0;
         vld_q     <= 1'b0;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lost_q    <= lost_d;
         rej_run_q <= rej_run_d;
         rej_tot_q <= rej_tot_d;
         vld_q     <= iVALID_COORD;
         upd_q     <= seed | push;
      end
   end

   // Result regs load one cycle after the history update
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oRow      <= '0;
         oCol      <= '0;
         oVALID    <= 1'b0;
         oTRACKING <= 1'b0;
      end else begin
         oTRACKING <= (state_d == TRACK);
         if (enter_lost)
            oVALID <= 1'b0;
         else if (upd_q) begin
            oRow   <= avg_row;
            oCol   <= avg_col;
            oVALID <= 1'b1;
         end else if (oVALID && iREADY)
            oVALID <= 1'b0;
      end
   end

   assign oREJECTS = rej_tot_q;

endmodule

// File: tb/tb_coord_smoother.sv
// Scoreboarded bench for coord_smoother: directed vectors,
// expected results queued at stimulus, checked on transfer.
module tb_coord_smoother;
   import img_proc_pkg::*;

   logic               iCLK = 1'b0;
   logic               iRST = 1'b1;
   logic [COORD_W-1:0] iRow = '0;
   logic [COORD_W-1:0] iCol = '0;
   logic               iVALID_COORD = 1'b0;
   logic               iFRAME_TICK = 1'b0;
   logic               iREADY = 1'b0;
   logic [COORD_W-1:0] oRow;
   logic [COORD_W-1:0] oCol;
   logic               oVALID;
   logic               oTRACKING;
   logic [7:0]         oREJECTS;

   coord_t exp_q[$];
   int     errors = 0;
   int     checks = 0;

   coord_smoother dut (
      .iCLK         (iCLK),
      .iRST         (iRST),
      .iRow         (iRow),
      .iCol         (iCol),
      .iVALID_COORD (iVALID_COORD),
      .iFRAME_TICK  (iFRAME_TICK),
      .iREADY       (iREADY),
      .oRow         (oRow),
      .oCol         (oCol),
      .oVALID       (oVALID),
      .oTRACKING    (oTRACKING),
      .oREJECTS     (oREJECTS)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endtask

   always @(negedge iCLK) begin
      coord_t e;
      if (iRST && oVALID && iREADY) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got (%0d,%0d) expected none",
                     oRow, oCol);
         end else begin
            e = exp_q.pop_front();
            if (oRow !== e.row || oCol !== e.col) begin
               errors++;
               $display("FAIL out_data: got (%0d,%0d) expected (%0d,%0d)",
                        oRow, oCol, e.row, e.col);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge iCLK);
         #1;
      end
   endtask

   task automatic push_exp(input int r, input int c);
      coord_t e;
      e.row = COORD_W'(r);
      e.col = COORD_W'(c);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      chk("queue_drained", exp_q.size(), 0);
      iVALID_COORD = 1'b0;
      iFRAME_TICK  = 1'b0;
      #2 iRST = 1'b0;
      #1;
      chk("rst_valid", oVALID, 0);
      chk("rst_tracking", oTRACKING, 0);
      chk("rst_rejects", oREJECTS, 0);
      chk("rst_row", oRow, 0);
      chk("rst_col", oCol, 0);
      cyc(2);
      iRST = 1'b1;
      cyc(1);
   endtask

   task automatic strobe(input int r, input int c);
      iRow = COORD_W'(r);
      iCol = COORD_W'(c);
      iVALID_COORD = 1'b1;
      cyc(1);
      iVALID_COORD = 1'b0;
      cyc(3);
   endtask

   task automatic ftick(input int n);
      repeat (n) begin
         iFRAME_TICK = 1'b1;
         cyc(1);
         iFRAME_TICK = 1'b0;
         cyc(1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // 1: held-high valid yields a single seeded output
      do_reset();
      iREADY = 1'b1;
      iRow = 11'd100;
      iCol = 11'd200;
      iVALID_COORD = 1'b1;
      push_exp(100, 200);
      cyc(1);
      chk("t1_valid_edge1", oVALID, 0);
      chk("t1_tracking", oTRACKING, 1);
      cyc(1);
      chk("t1_valid_edge2", oVALID, 1);
      cyc(48);
      iVALID_COORD = 1'b0;
      cyc(2);

      // 2: running average 101, 103, 106
      push_exp(101, 200);
      strobe(104, 200);
      push_exp(103, 200);
      strobe(108, 200);
      push_exp(106, 200);
      strobe(112, 200);

      // 3: outliers rejected, third consecutive reseeds
      do_reset();
      push_exp(100, 200);
      strobe(100, 200);
      strobe(300, 200);
      chk("t3_rej1", oREJECTS, 1);
      chk("t3_no_out", oVALID, 0);
      strobe(300, 200);
      chk("t3_rej2", oREJECTS, 2);
      push_exp(300, 200);
      strobe(300, 200);
      chk("t3_rej_after_seed", oREJECTS, 2);
      chk("t3_tracking", oTRACKING, 1);

      // 4: eight ticks without samples -> LOST
      do_reset();
      iREADY = 1'b0;
      strobe(10, 20);
      chk("t4_pending", oVALID, 1);
      ftick(7);
      chk("t4_track_7", oTRACKING, 1);
      chk("t4_pending_7", oVALID, 1);
      ftick(1);
      chk("t4_track_8", oTRACKING, 0);
      chk("t4_dropped", oVALID, 0);
      iREADY = 1'b1;
      push_exp(50, 60);
      strobe(50, 60);
      chk("t4_retrack", oTRACKING, 1);

      // 5: stalled consumer, latest result wins
      do_reset();
      iREADY = 1'b1;
      push_exp(100, 200);
      strobe(100, 200);
      iREADY = 1'b0;
      strobe(104, 200);
      strobe(108, 200);
      chk("t5_held", oVALID, 1);
      chk("t5_row", oRow, 103);
      cyc(3);
      chk("t5_stable", oRow, 103);
      push_exp(103, 200);
      iREADY = 1'b1;
      cyc(1);
      chk("t5_drop", oVALID, 0);

      // 6: tick with accepted strobe clears lost count
      do_reset();
      iREADY = 1'b1;
      push_exp(100, 200);
      strobe(100, 200);
      ftick(7);
      chk("t6_track_7", oTRACKING, 1);
      push_exp(101, 200);
      iRow = 11'd104;
      iCol = 11'd200;
      iVALID_COORD = 1'b1;
      iFRAME_TICK  = 1'b1;
      cyc(1);
      iVALID_COORD = 1'b0;
      iFRAME_TICK  = 1'b0;
      cyc(3);
      chk("t6_coinc", oTRACKING, 1);
      ftick(7);
      chk("t6_cleared", oTRACKING, 1);
      ftick(1);
      chk("t6_lost", oTRACKING, 0);
      iREADY = 1'b0;
      strobe(5, 6);
      strobe(500, 6);
      chk("t6_rej", oREJECTS, 1);
      chk("t6_pending", oVALID, 1);
      chk("t6_pend_row", oRow, 5);
      do_reset();

      chk("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
